mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Word-serial multi-precision adder sequencer for the Montgomery datapath.
- Computes NWORDS*WBITS-bit sums by driving one WBITS-wide add_3 word adder for NWORDS consecutive cycles, carrying between words through an internal register.
- Replaces a full-width adder where area matters, e.g. accumulator updates and final result assembly.
- Start/done handshake toward the Montgomery top-level controller.

Parameters:
- WBITS, 64: word width of the shared add_3 instance.
- NWORDS, 4: number of words per operand; NWORDS >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  NWORDS*WBITS  operand A; latched when start is accepted.
- b  in  NWORDS*WBITS  operand B; latched when start is accepted.
- sub  in  1  subtract mode; latched with operands. Port present only with MP_ADD_SUB_EN.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- y  out  NWORDS*WBITS  result register.
- cout  out  1  final carry (or no-borrow flag in subtract mode).

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, y=0, cout=0, carry=0, idx=0.
- Reset mid-operation aborts immediately. Partial results are discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k latches a, b (and sub), clears idx, sets carry=0 → RUN.
  - y and cout keep their last values.
- RUN:
  - Each cycle: add_3(a_word[idx], b_word[idx], carry).
  - Sum is written to y word idx; carry <= adder cout; idx++.
  - Words are processed LSW first.
  - After the word with idx=NWORDS-1: cout <= final carry → DONE.
- DONE:
  - done=1 for exactly one cycle → IDLE.
- Latency:
  - RUN occupies edges k+1..k+NWORDS.
  - done is high in the cycle following edge k+NWORDS.
  - Total NWORDS+1 cycles from start acceptance to done.
  - A new start is accepted in the cycle after done (back-to-back throughput NWORDS+2).
- start while busy (RUN or DONE): ignored, not queued. Operand changes during busy have no effect.
- y is not cleared on start. Words update progressively during RUN.
- y and cout are valid from done until the next accepted start. Consumers must not read y while busy.
- Arithmetic: y = (A + B) mod 2^(NWORDS*WBITS); cout = bit NWORDS*WBITS of the full sum.
- idx width is max(1, clog2(NWORDS)), and idx never exceeds NWORDS-1.
- NWORDS=1: a single RUN cycle, then DONE.

Optional Feature:
- Macro: MP_ADD_SUB_EN.
- Defined:
  - sub port exists.
  - sub=1 latched: the B word path is bitwise inverted and the initial carry is 1.
  - Result: y = (A - B) mod 2^N; cout=1 iff A >= B (no borrow).
  - sub=0 behaves exactly as without the macro.
- Undefined:
  - no sub port, no inverter, initial carry fixed at 0.
  - add-only, no area overhead.

Decomposition:
- Package mp_add_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparam function for the idx width;
  - NBITS_TOTAL constant helper.
- One sub-module: the existing add_3 word adder, instantiated once with NBITS=WBITS.
- The sequencer must not contain a second adder.

Test Plan (WBITS=4, NWORDS=4, 16-bit):
- a=0x00FF, b=0x0001 -> y=0x0100, cout=0, done high exactly 5 cycles after the start edge, busy high for 5 cycles.
- a=0xFFFF, b=0x0001 -> carry ripples through all words: y=0x0000, cout=1.
- start held high through the whole run, with a/b changed to 0x1111/0x2222 after acceptance of 0x0003+0x0004 -> y=0x0007; one done pulse; second start accepted only in the cycle after done.
- rst_n low in the 2nd RUN cycle -> busy=0, done=0, y=0, cout=0 immediately; next start a=0x1234, b=0x4321 -> y=0x5555, cout=0.
- (MP_ADD_SUB_EN) sub=1, a=0x0005, b=0x0007 -> y=0xFFFE, cout=0; sub=1, a=0x0007, b=0x0005 -> y=0x0002, cout=1.
- NWORDS=1, WBITS=8: a=0x80, b=0x80 -> y=0x00, cout=1, done 2 cycles after start.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and elaboration-time helpers for the word-serial
// multi-precision adder sequencer (mp_add_seq).
//   state_e      - sequencer states
//   idx_width()  - word-index register width, never narrower than 1 bit
//   nbits_total()- full operand width in bits
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned nwords);
        int unsigned w;
        w = $clog2(nwords);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned nbits_total(input int unsigned wbits,
                                                input int unsigned nwords);
        return wbits * nwords;
    endfunction

endpackage

// File: rtl/mp_add_seq_add_3.sv
// add_3: NBITS-wide three-input word adder (a + b + cin).
// Ports:
//   a, b  in  NBITS  addends
//   cin   in  1      carry in
//   s     out NBITS  sum (mod 2^NBITS)
//   cout  out 1      carry out
module add_3 #(
    parameter int unsigned NBITS = 64
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             cin,
    output logic [NBITS-1:0] s,
    output logic             cout
);

    logic [NBITS:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{NBITS{1'b0}}, cin};
    end

    assign s    = full[NBITS-1:0];
    assign cout = full[NBITS];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: word-serial multi-precision adder sequencer.
// Adds two NWORDS*WBITS-bit operands by stepping one WBITS-wide add_3 over the
// words, least significant first, carrying between words in a register.
// Optional macro MP_ADD_SUB_EN adds the 'sub' port: B is inverted and the
// initial carry is 1, giving A - B with cout = no-borrow.
// Ports:
//   clk    in   1              clock, rising edge
//   rst_n  in   1              asynchronous active-low reset
//   start  in   1              request, sampled only in IDLE
//   a, b   in   NWORDS*WBITS   operands, latched on accepted start
//   sub    in   1              subtract mode (MP_ADD_SUB_EN only)
//   busy   out  1              state != IDLE
//   done   out  1              one-cycle completion pulse
//   y      out  NWORDS*WBITS   result register
//   cout   out  1              final carry / no-borrow flag
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned WBITS  = 64,
    parameter int unsigned NWORDS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [nbits_total(WBITS, NWORDS)-1:0]  a,
    input  logic [nbits_total(WBITS, NWORDS)-1:0]  b,
`ifdef MP_ADD_SUB_EN
    input  logic                                   sub,
`endif
    output logic                                   busy,
    output logic                                   done,
    output logic [nbits_total(WBITS, NWORDS)-1:0]  y,
    output logic                                   cout
);

    localparam int unsigned IW = idx_width(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_e                         state_q, state_d;
    logic [NWORDS-1:0][WBITS-1:0]   a_q, a_d;
    logic [NWORDS-1:0][WBITS-1:0]   b_q, b_d;
    logic [NWORDS-1:0][WBITS-1:0]   y_q, y_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           carry_q, carry_d;
    logic                           cout_q, cout_d;
`ifdef MP_ADD_SUB_EN
    logic                           sub_q, sub_d;
`endif

    logic [WBITS-1:0] a_w;
    logic [WBITS-1:0] b_w;
    logic [WBITS-1:0] b_eff;
    logic [WBITS-1:0] sum_w;
    logic             c_w;

    // Word select for the current index.
    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_w = a_q[i];
                b_w = b_q[i];
            end
        end
    end

`ifdef MP_ADD_SUB_EN
    assign b_eff = sub_q ? ~b_w : b_w;
`else
    assign b_eff = b_w;
`endif

    add_3 #(
        .NBITS (WBITS)
    ) u_add_3 (
        .a    (a_w),
        .b    (b_eff),
        .cin  (carry_q),
        .s    (sum_w),
        .cout (c_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef MP_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef MP_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
`ifdef MP_ADD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NWORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        y_d[i] = sum_w;
                    end
                end
                carry_d = c_w;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c_w;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign y    = y_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed self-checking bench for mp_add_seq.
// Instance dut: WBITS=4, NWORDS=4 (16-bit); instance dut1: WBITS=8, NWORDS=1.
// Subtract vectors are exercised when MP_ADD_SUB_EN is defined.
module tb_mp_add_seq;

    logic        clk;
    logic        rst_n;

    logic        start0;
    logic [15:0] a0, b0;
    logic        busy0, done0, cout0;
    logic [15:0] y0;

    logic        start1;
    logic [7:0]  a1, b1;
    logic        busy1, done1, cout1;
    logic [7:0]  y1;

`ifdef MP_ADD_SUB_EN
    logic        sub0;
    logic        sub1;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    mp_add_seq #(
        .WBITS  (4),
        .NWORDS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .a     (a0),
        .b     (b0),
`ifdef MP_ADD_SUB_EN
        .sub   (sub0),
`endif
        .busy  (busy0),
        .done  (done0),
        .y     (y0),
        .cout  (cout0)
    );

    mp_add_seq #(
        .WBITS  (8),
        .NWORDS (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
`ifdef MP_ADD_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .y     (y1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on either instance; observes 12 cycles after acceptance.
    task automatic run_op(input string tag, input bit one,
                          input logic [15:0] av, input logic [15:0] bv, input bit sv,
                          input logic [15:0] ey, input logic ec);
        int lat;
        int bcnt;
        int pulses;
        lat = -1;
        bcnt = 0;
        pulses = 0;
        @(negedge clk);
        if (one) begin
            start1 = 1'b1; a1 = av[7:0]; b1 = bv[7:0];
        end else begin
            start0 = 1'b1; a0 = av; b0 = bv;
        end
`ifdef MP_ADD_SUB_EN
        sub0 = sv;
        sub1 = sv;
`else
        if (sv) $display("run_op %s: subtract requested without MP_ADD_SUB_EN", tag);
`endif
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (one ? busy1 : busy0) bcnt++;
            if (one ? done1 : done0) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check({tag, "_lat"},    lat,    one ? 1 : 4);
        check({tag, "_busy"},   bcnt,   one ? 2 : 5);
        check({tag, "_pulses"}, pulses, 1);
        if (one) begin
            check({tag, "_y"},    {24'd0, y1}, {24'd0, ey[7:0]});
            check({tag, "_cout"}, {31'd0, cout1}, {31'd0, ec});
        end else begin
            check({tag, "_y"},    {16'd0, y0}, {16'd0, ey});
            check({tag, "_cout"}, {31'd0, cout0}, {31'd0, ec});
        end
    endtask

    initial begin
        int pulses;
        n_tests = 0;
        n_fail  = 0;
        rst_n  = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
`ifdef MP_ADD_SUB_EN
        sub0 = 1'b0;
        sub1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_y",    {16'd0, y0},    32'd0);
        check("rst_cout", {31'd0, cout0}, 32'd0);
        check("rst1_y",   {24'd0, y1},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ff_1",   1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        run_op("ripple",     1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("add_mix",    1'b0, 16'h8765, 16'h89AB, 1'b0, 16'h1110, 1'b1);

        // start held high for the whole run, operands changed after acceptance
        @(negedge clk);
        start0 = 1'b1; a0 = 16'h0003; b0 = 16'h0004;
        @(posedge clk);
        #1;
        a0 = 16'h1111; b0 = 16'h2222;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (done0) pulses++;
            if (i == 4) begin
                check("hold_done",  {31'd0, done0}, 32'd1);
                check("hold_y",     {16'd0, y0},    32'h0007);
                check("hold_cout",  {31'd0, cout0}, 32'd0);
            end
            if (i == 5) check("hold_idle_busy", {31'd0, busy0}, 32'd0);
            if (i == 6) check("hold_restart",   {31'd0, busy0}, 32'd1);
        end
        check("hold_pulses", pulses, 1);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        check("hold2_y",    {16'd0, y0},    32'h3333);
        check("hold2_cout", {31'd0, cout0}, 32'd0);

        // reset in the second RUN cycle
        @(negedge clk);
        start0 = 1'b1; a0 = 16'h0F0F; b0 = 16'h0101;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_done", {31'd0, done0}, 32'd0);
        check("abort_y",    {16'd0, y0},    32'd0);
        check("abort_cout", {31'd0, cout0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_abort", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

`ifdef MP_ADD_SUB_EN
        run_op("sub_neg",  1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_pos",  1'b0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
        run_op("sub_eq",   1'b0, 16'h0009, 16'h0009, 1'b1, 16'h0000, 1'b1);
        run_op("sub_off",  1'b0, 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0);
`endif

        run_op("w1_80_80", 1'b1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1);
        run_op("w1_12_34", 1'b1, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
